// File: rtl/smvm_batch_scheduler.sv
`default_nettype none
// == smvm_batch_scheduler : SMVM job parser, vector writer and K-lane batch issuer == rev 1.0 ==
module smvm_batch_scheduler #(
  parameter int K  = 4,
  parameter int VW = 8,
  parameter int CW = 7,
  parameter int RW = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [VW-1:0]     in_data,
  input  logic [CW-1:0]     in_col,
  input  logic              in_ipv,
  input  logic              in_last,
  output logic              vec_we,
  output logic [CW-1:0]     vec_waddr,
  output logic [VW-1:0]     vec_wdata,
  output logic              iss_valid,
  input  logic              iss_ready,
  output logic [K*VW-1:0]   iss_val,
  output logic [K*CW-1:0]   iss_col,
  output logic [K-1:0]      iss_ipv,
  output logic [K-1:0]      iss_mask,
  output logic              iss_last,
  output logic              busy,
  output logic              done,
  output logic [RW-1:0]     row_count,
  output logic              err
);

  localparam int LW = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_COLS  = 3'd1,
    S_VEC   = 3'd2,
    S_NZ    = 3'd3,
    S_DRAIN = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t            r_state;
  logic [RW-1:0]     r_rows;
  logic [CW-1:0]     r_cols;
  logic [CW:0]       r_vec_cnt;
  logic [LW-1:0]     r_lane;
  logic [K*VW-1:0]   r_acc_val;
  logic [K*CW-1:0]   r_acc_col;
  logic [K-1:0]      r_acc_ipv;
  logic [K-1:0]      r_acc_mask;

  logic              w_xfer;
  logic              w_nz_xfer;
  logic              w_iss_xfer;
  logic              w_batch_done;
  logic              w_cols_last;
  logic [K*VW-1:0]   w_bval;
  logic [K*CW-1:0]   w_bcol;
  logic [K-1:0]      w_bipv;
  logic [K-1:0]      w_bmask;

  always_comb begin
    in_ready = 1'b0;
    case (r_state)
      S_IDLE, S_COLS, S_VEC: in_ready = 1'b1;
      S_NZ:                  in_ready = !iss_valid || iss_ready;
      default:               in_ready = 1'b0;
    endcase
  end

  assign w_xfer       = in_valid && in_ready;
  assign w_nz_xfer    = w_xfer && (r_state == S_NZ);
  assign w_iss_xfer   = iss_valid && iss_ready;
  assign w_batch_done = w_nz_xfer && ((r_lane == LW'(K-1)) || in_last);
  assign w_cols_last  = (r_vec_cnt == ({1'b0, r_cols} - (CW+1)'(1)));

  assign vec_we    = w_xfer && (r_state == S_VEC);
  assign vec_waddr = r_vec_cnt[CW-1:0];
  assign vec_wdata = in_data;

  assign busy = (r_state != S_IDLE);
  assign done = (r_state == S_DONE);

  // Accumulated lanes plus the beat being accepted; lanes above it are still zero.
  always_comb begin
    w_bval  = r_acc_val;
    w_bcol  = r_acc_col;
    w_bipv  = r_acc_ipv;
    w_bmask = r_acc_mask;
    for (int i = 0; i < K; i++) begin
      if (LW'(i) == r_lane) begin
        w_bval[i*VW +: VW] = in_data;
        w_bcol[i*CW +: CW] = in_col;
        w_bipv[i]          = in_ipv;
        w_bmask[i]         = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_rows     <= '0;
      r_cols     <= '0;
      r_vec_cnt  <= '0;
      r_lane     <= '0;
      r_acc_val  <= '0;
      r_acc_col  <= '0;
      r_acc_ipv  <= '0;
      r_acc_mask <= '0;
      iss_valid  <= 1'b0;
      iss_val    <= '0;
      iss_col    <= '0;
      iss_ipv    <= '0;
      iss_mask   <= '0;
      iss_last   <= 1'b0;
      row_count  <= '0;
      err        <= 1'b0;
    end else begin
      // A completing batch may load in the same cycle the previous one leaves.
      if (w_batch_done) begin
        iss_valid <= 1'b1;
        iss_val   <= w_bval;
        iss_col   <= w_bcol;
        iss_ipv   <= w_bipv;
        iss_mask  <= w_bmask;
        iss_last  <= in_last;
      end else if (w_iss_xfer) begin
        iss_valid <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (w_xfer) begin
            r_rows    <= RW'(in_data);
            row_count <= '0;
            err       <= 1'b0;
            r_state   <= S_COLS;
          end
        end
        S_COLS: begin
          if (w_xfer) begin
            r_cols    <= in_data[CW-1:0];
            r_vec_cnt <= '0;
            if (in_data[CW-1:0] != '0)
              r_state <= S_VEC;
            else if (r_rows == '0)
              r_state <= S_DONE;
            else
              r_state <= S_NZ;
          end
        end
        S_VEC: begin
          if (w_xfer) begin
            r_vec_cnt <= r_vec_cnt + (CW+1)'(1);
            if (w_cols_last)
              r_state <= (r_rows == '0) ? S_DONE : S_NZ;
          end
        end
        S_NZ: begin
          if (w_nz_xfer) begin
            if (in_ipv && (row_count != '1))
              row_count <= row_count + RW'(1);
            if (w_batch_done) begin
              r_acc_val  <= '0;
              r_acc_col  <= '0;
              r_acc_ipv  <= '0;
              r_acc_mask <= '0;
              r_lane     <= '0;
            end else begin
              r_acc_val  <= w_bval;
              r_acc_col  <= w_bcol;
              r_acc_ipv  <= w_bipv;
              r_acc_mask <= w_bmask;
              r_lane     <= r_lane + LW'(1);
            end
            if (in_last)
              r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (w_iss_xfer)
            r_state <= S_DONE;
        end
        S_DONE: begin
          err     <= (row_count != r_rows);
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
